// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption sequencer: one shared inverse-round datapath,
// round keys fetched by index from an external key-schedule store.
module aes_dec_iter_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;
  localparam logic [RND_W-1:0] LAST_KEY  = RND_W'(10);
  localparam logic [RND_W-1:0] FIRST_RND = RND_W'(9);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t             r_state;
  logic [BLK_W-1:0]   r_st;
  logic [RND_W-1:0]   r_rnd;
  logic [BLK_W-1:0]   r_pt;
  logic               r_out_valid;
  logic [BLK_W-1:0]   w_isb;
  logic [BLK_W-1:0]   w_ark;
  logic [BLK_W-1:0]   w_imc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254 by repeated squaring; maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*(((c-r)+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Shared datapath; FINAL taps it before InvMixColumns
  assign w_isb = inv_sub_bytes(inv_shift_rows(r_st));
  assign w_ark = w_isb ^ rk;
  assign w_imc = inv_mix_columns(w_ark);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign plaintext = r_pt;

  always_comb begin
    rk_idx = LAST_KEY;
    case (r_state)
      S_ROUND: rk_idx = r_rnd;
      S_FINAL: rk_idx = '0;
      default: rk_idx = LAST_KEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_st        <= '0;
      r_rnd       <= '0;
      r_pt        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_st    <= ciphertext ^ rk;
            r_rnd   <= FIRST_RND;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_st <= w_imc;
          if (r_rnd == RND_W'(1)) r_state <= S_FINAL;
          else                    r_rnd   <= r_rnd - RND_W'(1);
        end
        S_FINAL: begin
          r_pt        <= w_ark;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Bench for aes_dec_iter_ctrl: FIPS-197 vectors plus random blocks produced
// by an encrypt-direction AES-128 model, so a correct decrypt returns the input.
module tb_aes_dec_iter_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  logic [7:0]   sbox [256];
  logic [127:0] rkeys [11];
  int errors = 0;
  int checks = 0;

  aes_dec_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext)
  );

  always #5 clk = ~clk;

  // Key-schedule store: combinational lookup by index
  always_comb begin
    rk = '0;
    if (rk_idx < 4'd11) rk = rkeys[rk_idx];
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Forward S-box from a brute-force field inverse and the affine map
  task automatic build_sbox();
    logic [7:0] v;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      v = 8'(x);
      inv = 8'h00;
      if (v != 8'h00)
        for (int y = 1; y < 256; y++)
          if (gm(v, 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = pt[127-8*i -: 8] ^ rkeys[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[b[i]];
      for (int i = 0; i < 16; i++) b[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
          b[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          b[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          b[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          b[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) b[i] = b[i] ^ rkeys[r][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  // Brings the DUT to IDLE with no output pending, ending on a falling edge
  task automatic idle_sync();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((!in_ready || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Sends one block with out_ready high; lat = falling edges after accept until out_valid
  task automatic send_and_wait(input logic [127:0] ct, output logic [127:0] pt_o, output int lat);
    int n;
    in_valid = 1'b1;
    ciphertext = ct;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    pt_o = plaintext;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ciphertext = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL reset_rk_idx: got %0d want 10", rk_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (plaintext !== 128'h0) begin errors++; $display("FAIL reset_plaintext: got %h want 0", plaintext); end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_out_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_fips_c1();
    logic [3:0] exp_idx;
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    checks++; if (rkeys[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++; $display("FAIL model_rk10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", rkeys[10]); end
    idle_sync();
    in_valid = 1'b1;
    ciphertext = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    checks++; if (in_ready !== 1'b1 || rk_idx !== 4'd10) begin
      errors++; $display("FAIL c1_idle: in_ready=%b rk_idx=%0d want 1/10", in_ready, rk_idx); end
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) in_valid = 1'b0;
      exp_idx = (j <= 8) ? 4'(9 - j) : (j == 9) ? 4'd0 : 4'd10;
      checks++; if (rk_idx !== exp_idx) begin
        errors++; $display("FAIL c1_rk_idx[%0d]: got %0d want %0d", j, rk_idx, exp_idx); end
      checks++; if (out_valid !== (j == 10)) begin
        errors++; $display("FAIL c1_out_valid[%0d]: got %b want %b", j, out_valid, (j == 10)); end
      if (j == 10) begin
        checks++; if (plaintext !== 128'h00112233445566778899aabbccddeeff) begin
          errors++; $display("FAIL c1_plaintext: got %h want 00112233445566778899aabbccddeeff", plaintext); end
      end
    end
  endtask

  task automatic test_fips_b();
    logic [127:0] pt;
    int lat;
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    idle_sync();
    send_and_wait(128'h3925841d02dc09fbdc118597196a0b32, pt, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL b_latency: got %0d want 10", lat); end
    checks++; if (pt !== 128'h3243f6a8885a308d313198a2e0370734) begin
      errors++; $display("FAIL b_plaintext: got %h want 3243f6a8885a308d313198a2e0370734", pt); end
  endtask

  task automatic test_backpressure();
    logic [127:0] pa, pb;
    int n;
    pa = rnd128(); pb = rnd128();
    idle_sync();
    out_ready = 1'b0;
    in_valid = 1'b1;
    ciphertext = enc(pa);
    @(posedge clk);
    @(negedge clk);
    ciphertext = enc(pb);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (plaintext !== pa || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_first: got %h valid=%b want %h valid=1", plaintext, out_valid, pa); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (plaintext !== pa || out_valid !== 1'b1 || in_ready !== 1'b0 || rk_idx !== 4'd10) begin
        errors++; $display("FAIL bp_hold[%0d]: pt=%h valid=%b in_ready=%b rk_idx=%0d want %h/1/0/10",
                           k, plaintext, out_valid, in_ready, rk_idx, pa); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (rk_idx !== 4'd9) begin errors++; $display("FAIL bp_second_accept: rk_idx=%0d want 9", rk_idx); end
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 11) begin errors++; $display("FAIL bp_second_delay: got %0d want 11", n); end
    checks++; if (plaintext !== pb) begin errors++; $display("FAIL bp_second_pt: got %h want %h", plaintext, pb); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [8];
    logic [127:0] cts [8];
    int acc [$];
    int nout, idx;
    bit pend;
    set_key(rnd128());
    for (int i = 0; i < 8; i++) begin
      pts[i] = rnd128();
      cts[i] = enc(pts[i]);
    end
    idle_sync();
    nout = 0; idx = 0; pend = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    ciphertext = cts[0];
    for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pend) begin
        idx++;
        pend = 1'b0;
        if (idx < 8) ciphertext = cts[idx];
        else         in_valid = 1'b0;
      end
      if (out_valid) begin
        checks++; if (plaintext !== pts[nout]) begin
          errors++; $display("FAIL b2b_pt[%0d]: got %h want %h", nout, plaintext, pts[nout]); end
        nout++;
      end
      if (in_valid && in_ready) begin
        acc.push_back(cyc);
        pend = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++; if (nout !== 8 || acc.size() !== 8) begin
      errors++; $display("FAIL b2b_count: outputs=%0d accepts=%0d want 8/8", nout, acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++; if (acc[i] - acc[i-1] !== 12) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 12", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pa, pb;
    int n;
    set_key(rnd128());
    pa = rnd128(); pb = rnd128();
    idle_sync();
    in_valid = 1'b1;
    ciphertext = enc(pa);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rk_idx !== 4'd5) begin errors++; $display("FAIL rm_reach_round5: rk_idx=%0d want 5", rk_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || plaintext !== 128'h0 || in_ready !== 1'b1 || rk_idx !== 4'd10) begin
      errors++; $display("FAIL rm_async: valid=%b pt=%h in_ready=%b rk_idx=%0d want 0/0/1/10",
                         out_valid, plaintext, in_ready, rk_idx); end
    in_valid = 1'b1;
    ciphertext = enc(pb);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || rk_idx !== 4'd10) begin
      errors++; $display("FAIL rm_held: valid=%b rk_idx=%0d want 0/10", out_valid, rk_idx); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (rk_idx !== 4'd9) begin errors++; $display("FAIL rm_first_accept: rk_idx=%0d want 9", rk_idx); end
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL rm_latency: got %0d want 10", n); end
    checks++; if (plaintext !== pb) begin errors++; $display("FAIL rm_pt: got %h want %h", plaintext, pb); end
  endtask

  task automatic test_protocol();
    logic [127:0] exp_q [$];
    logic [127:0] pr, want;
    int nacc, nout, n;
    set_key(rnd128());
    idle_sync();
    nacc = 0; nout = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      pr = rnd128();
      ciphertext = enc(pr);
      in_valid = 1'($urandom_range(1, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(pr);
        nacc++;
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++; if (plaintext !== want) begin
          errors++; $display("FAIL proto_pt[%0d]: got %h want %h", nout, plaintext, want); end
        nout++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        want = exp_q.pop_front();
        checks++; if (plaintext !== want) begin
          errors++; $display("FAIL proto_drain_pt[%0d]: got %h want %h", nout, plaintext, want); end
        nout++;
      end
    end
    checks++; if (nout !== nacc || nacc == 0) begin
      errors++; $display("FAIL proto_count: outputs=%0d accepts=%0d want equal and nonzero", nout, nacc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    build_sbox();
    for (int r = 0; r < 11; r++) rkeys[r] = '0;
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
